pcd8544_spi_responder: RTL and testbench

//   SPI Mode-0 responder emulating a PCD8544 (Nokia 5110) LCD controller: deserializes MOSI

---
 rtl/pcd8544_spi_responder_pkg.sv | 43 ++++
 rtl/pcd8544_spi_responder_spi_byte_rx.sv | 112 +++++++++++
 rtl/pcd8544_spi_responder.sv | 177 +++++++++++++++++
 tb/tb_pcd8544_spi_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pcd8544_spi_responder_pkg.sv
// rtl/pcd8544_spi_responder_pkg.sv - PCD8544 geometry, opcode patterns, reset values
// Purpose: shared constants, byte-FSM state type and framebuffer address helper.
// Ports:   none (package).
package pcd8544_spi_responder_pkg;

    localparam int LCD_COLS  = 84;
    localparam int LCD_BANKS = 6;
    localparam int FB_DEPTH  = LCD_COLS * LCD_BANKS;

    localparam logic [2:0] PD_V_H_RESET = 3'b100;

    // Command opcodes: (byte & MASK) == VAL
    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_FUNC_MASK = 8'hE0;
    localparam logic [7:0] OP_FUNC_VAL  = 8'h20;
    localparam logic [7:0] OP_DISP_MASK = 8'hFA;
    localparam logic [7:0] OP_DISP_VAL  = 8'h08;
    localparam logic [7:0] OP_SETY_MASK = 8'hF8;
    localparam logic [7:0] OP_SETY_VAL  = 8'h40;
    localparam logic [7:0] OP_TC_MASK   = 8'hFC;
    localparam logic [7:0] OP_TC_VAL    = 8'h04;
    localparam logic [7:0] OP_BIAS_MASK = 8'hF8;
    localparam logic [7:0] OP_BIAS_VAL  = 8'h10;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_COMMIT = 2'd2
    } rx_state_t;

    function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                      input logic [7:0] val);
        return (b & mask) == val;
    endfunction

    // Y*84 + X built from shifts: 84 = 64 + 16 + 4
    function automatic logic [8:0] fb_addr(input logic [6:0] x, input logic [2:0] y);
        logic [8:0] ye;
        ye = {6'd0, y};
        return (ye << 6) + (ye << 4) + (ye << 2) + {2'd0, x};
    endfunction

endpackage

// File: rtl/pcd8544_spi_responder_spi_byte_rx.sv
// rtl/pcd8544_spi_responder_spi_byte_rx.sv - SPI mode-0 byte deserializer with CE/DC capture
// Purpose: synchronize SPI/LCD pins, detect SCLK rises, assemble MSB-first bytes.
// Ports:   i_Clk, i_Rst        system clock, sync active-high reset
//          i_SPI_Clk/MOSI      async SPI pins
//          i_LCD_CE/DC/RST     async LCD control pins (CE, RST active low)
//          lcd_rst_active      synced LCD_RST is asserted
//          rx_byte/rx_is_data  last completed byte and its DC bit
//          rx_dv               1-cycle pulse per completed byte
module spi_byte_rx
    import pcd8544_spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_LCD_CE,
    input  logic       i_LCD_DC,
    input  logic       i_LCD_RST,
    output logic       lcd_rst_active,
    output logic [7:0] rx_byte,
    output logic       rx_is_data,
    output logic       rx_dv
);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ce_sync, dc_sync, rst_sync;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ce_sync   <= '1;
            dc_sync   <= '0;
            rst_sync  <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            ce_sync   <= {ce_sync[SYNC_STAGES-2:0],   i_LCD_CE};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   i_LCD_DC};
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0],  i_LCD_RST};
        end
    end

    logic soft_rst, ce_n, sclk_rise, mosi_bit, dc_bit;

    assign lcd_rst_active = ~rst_sync[SYNC_STAGES-1];
    assign soft_rst       = i_Rst | lcd_rst_active;
    assign ce_n           = ce_sync[SYNC_STAGES-1];
    assign sclk_rise      = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
    // Take MOSI/DC from the same stage that first shows SCLK high
    assign mosi_bit       = mosi_sync[SYNC_STAGES-2];
    assign dc_bit         = dc_sync[SYNC_STAGES-2];

    rx_state_t  state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic       shift_en, byte_done;

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!ce_n) begin
                    state_nxt = RX_SHIFT;
                    shift_en  = sclk_rise;
                end
            end
            RX_SHIFT: begin
                if (ce_n) begin
                    state_nxt = RX_IDLE;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        byte_done = 1'b1;
                        state_nxt = RX_COMMIT;
                    end
                end
            end
            RX_COMMIT: state_nxt = ce_n ? RX_IDLE : RX_SHIFT;
            default:   state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (soft_rst) begin
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 7'd0;
            rx_byte    <= 8'd0;
            rx_is_data <= 1'b0;
        end else begin
            state <= state_nxt;
            // Leaving for IDLE (CE high) throws away any partial byte
            if (state_nxt == RX_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[5:0], mosi_bit};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                rx_byte    <= {shift_reg, mosi_bit};
                rx_is_data <= dc_bit;
            end
        end
    end

    assign rx_dv = (state == RX_COMMIT) && !soft_rst;

endmodule

// File: rtl/pcd8544_spi_responder.sv
// rtl/pcd8544_spi_responder.sv - PCD8544 LCD controller emulator behind an SPI responder
// Purpose: decode PCD8544 commands, hold controller registers, write 84x6 framebuffer.
// Ports:   i_Clk, i_Rst                 system clock, sync active-high reset
//          i_SPI_Clk/MOSI, i_LCD_CE/DC/RST   LCD pin inputs (async)
//          i_Rd_Addr/o_Rd_Data          framebuffer read port, 1-cycle latency
//          o_Byte_DV/o_Byte/o_Byte_Is_Data   received byte stream
//          o_PD_V_H/o_Disp_DE/o_Vop/o_TC/o_Bias/o_X/o_Y   controller state
//          o_Cmd_Err/o_Frame_Done       1-cycle event pulses
module pcd8544_spi_responder
    import pcd8544_spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_LCD_CE,
    input  logic       i_LCD_DC,
    input  logic       i_LCD_RST,
    input  logic [8:0] i_Rd_Addr,
    output logic [7:0] o_Rd_Data,
    output logic       o_Byte_DV,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Is_Data,
    output logic [2:0] o_PD_V_H,
    output logic [1:0] o_Disp_DE,
    output logic [6:0] o_Vop,
    output logic [1:0] o_TC,
    output logic [2:0] o_Bias,
    output logic [6:0] o_X,
    output logic [2:0] o_Y,
    output logic       o_Cmd_Err,
    output logic       o_Frame_Done
);

    localparam logic [6:0] LAST_X = 7'(LCD_COLS - 1);
    localparam logic [2:0] LAST_Y = 3'(LCD_BANKS - 1);

    logic       lcd_rst_active, soft_rst, rx_dv, rx_is_data;
    logic [7:0] rx_byte;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .i_Clk          (i_Clk),
        .i_Rst          (i_Rst),
        .i_SPI_Clk      (i_SPI_Clk),
        .i_SPI_MOSI     (i_SPI_MOSI),
        .i_LCD_CE       (i_LCD_CE),
        .i_LCD_DC       (i_LCD_DC),
        .i_LCD_RST      (i_LCD_RST),
        .lcd_rst_active (lcd_rst_active),
        .rx_byte        (rx_byte),
        .rx_is_data     (rx_is_data),
        .rx_dv          (rx_dv)
    );

    assign soft_rst       = i_Rst | lcd_rst_active;
    assign o_Byte_DV      = rx_dv;
    assign o_Byte         = rx_byte;
    assign o_Byte_Is_Data = rx_is_data;

    logic [2:0] pd_v_h, pd_v_h_nxt;
    logic [1:0] disp_de, disp_de_nxt;
    logic [6:0] vop, vop_nxt, x, x_nxt;
    logic [1:0] tc, tc_nxt;
    logic [2:0] bias, bias_nxt, y, y_nxt;
    logic       cmd_err, frame_done, fb_we;

    always_comb begin
        pd_v_h_nxt  = pd_v_h;
        disp_de_nxt = disp_de;
        vop_nxt     = vop;
        tc_nxt      = tc;
        bias_nxt    = bias;
        x_nxt       = x;
        y_nxt       = y;
        cmd_err     = 1'b0;
        frame_done  = 1'b0;
        fb_we       = 1'b0;
        if (rx_dv && !rx_is_data) begin
            if (rx_byte == OP_NOP) begin
                cmd_err = 1'b0;
            end else if (op_match(rx_byte, OP_FUNC_MASK, OP_FUNC_VAL)) begin
                pd_v_h_nxt = rx_byte[2:0];
            end else if (!pd_v_h[0]) begin
                if (rx_byte[7]) begin
                    if (rx_byte[6:0] <= LAST_X) x_nxt = rx_byte[6:0];
                    else                        cmd_err = 1'b1;
                end else if (op_match(rx_byte, OP_SETY_MASK, OP_SETY_VAL)) begin
                    if (rx_byte[2:0] <= LAST_Y) y_nxt = rx_byte[2:0];
                    else                        cmd_err = 1'b1;
                end else if (op_match(rx_byte, OP_DISP_MASK, OP_DISP_VAL)) begin
                    disp_de_nxt = {rx_byte[2], rx_byte[0]};
                end else begin
                    cmd_err = 1'b1;
                end
            end else begin
                if (rx_byte[7])                                        vop_nxt  = rx_byte[6:0];
                else if (op_match(rx_byte, OP_BIAS_MASK, OP_BIAS_VAL)) bias_nxt = rx_byte[2:0];
                else if (op_match(rx_byte, OP_TC_MASK, OP_TC_VAL))     tc_nxt   = rx_byte[1:0];
                else                                                   cmd_err  = 1'b1;
            end
        end else if (rx_dv && !pd_v_h[2]) begin
            fb_we = 1'b1;
            // Both addressing modes wrap the whole frame only at (83,5)
            if (!pd_v_h[1]) begin
                if (x == LAST_X) begin
                    x_nxt = 7'd0;
                    if (y == LAST_Y) begin
                        y_nxt      = 3'd0;
                        frame_done = 1'b1;
                    end else begin
                        y_nxt = y + 3'd1;
                    end
                end else begin
                    x_nxt = x + 7'd1;
                end
            end else begin
                if (y == LAST_Y) begin
                    y_nxt = 3'd0;
                    if (x == LAST_X) begin
                        x_nxt      = 7'd0;
                        frame_done = 1'b1;
                    end else begin
                        x_nxt = x + 7'd1;
                    end
                end else begin
                    y_nxt = y + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (soft_rst) begin
            pd_v_h  <= PD_V_H_RESET;
            disp_de <= 2'd0;
            vop     <= 7'd0;
            tc      <= 2'd0;
            bias    <= 3'd0;
            x       <= 7'd0;
            y       <= 3'd0;
        end else begin
            pd_v_h  <= pd_v_h_nxt;
            disp_de <= disp_de_nxt;
            vop     <= vop_nxt;
            tc      <= tc_nxt;
            bias    <= bias_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
        end
    end

    assign o_PD_V_H     = pd_v_h;
    assign o_Disp_DE    = disp_de;
    assign o_Vop        = vop;
    assign o_TC         = tc;
    assign o_Bias       = bias;
    assign o_X          = x;
    assign o_Y          = y;
    assign o_Cmd_Err    = cmd_err;
    assign o_Frame_Done = frame_done;

    // Framebuffer is never cleared by reset; read returns pre-write data on collision
    logic [7:0] fb [0:FB_DEPTH-1];

    always_ff @(posedge i_Clk) begin
        if (fb_we) fb[fb_addr(x, y)] <= rx_byte;
    end

    always_ff @(posedge i_Clk) begin
        if (soft_rst)                        o_Rd_Data <= 8'd0;
        else if (i_Rd_Addr < 9'(FB_DEPTH))   o_Rd_Data <= fb[i_Rd_Addr];
        else                                 o_Rd_Data <= 8'd0;
    end

endmodule

// File: tb/tb_pcd8544_spi_responder.sv
// tb/tb_pcd8544_spi_responder.sv - directed bench for pcd8544_spi_responder
module tb_pcd8544_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, mosi = 1'b0, ce = 1'b1, dc = 1'b0, lcd_rst = 1'b1;
    logic [8:0] rd_addr = 9'd0;
    logic [7:0] rd_data, byte_o;
    logic       byte_dv, byte_is_data, cmd_err, frame_done;
    logic [2:0] pd_v_h, bias, y_o;
    logic [1:0] disp_de, tc;
    logic [6:0] vop, x_o;

    int total = 0, bad = 0;
    int dv_cnt = 0, fd_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    pcd8544_spi_responder #(.SYNC_STAGES(2)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
        .i_LCD_CE(ce), .i_LCD_DC(dc), .i_LCD_RST(lcd_rst),
        .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data),
        .o_Byte_DV(byte_dv), .o_Byte(byte_o), .o_Byte_Is_Data(byte_is_data),
        .o_PD_V_H(pd_v_h), .o_Disp_DE(disp_de), .o_Vop(vop), .o_TC(tc), .o_Bias(bias),
        .o_X(x_o), .o_Y(y_o), .o_Cmd_Err(cmd_err), .o_Frame_Done(frame_done)
    );

    always @(negedge clk) begin
        if (byte_dv)    dv_cnt++;
        if (frame_done) fd_cnt++;
        if (cmd_err)    err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        ce = 1'b0;
        dc = d;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        repeat (4) @(negedge clk);
        ce = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_fb(input int a, output logic [7:0] d);
        rd_addr = 9'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    typedef struct {
        logic [7:0] b;
        logic [2:0] pvh;
        logic [1:0] de;
        logic [6:0] vop;
        logic [1:0] tc;
        logic [2:0] bias;
        logic [6:0] x;
        logic [2:0] y;
        int         err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [7:0] d;
        int e0, f0, v0;

        vecs[0]  = '{8'h21, 3'b001, 2'b00, 7'h00, 2'd0, 3'd0, 7'd0,  3'd0, 0};
        vecs[1]  = '{8'hB1, 3'b001, 2'b00, 7'h31, 2'd0, 3'd0, 7'd0,  3'd0, 0};
        vecs[2]  = '{8'h20, 3'b000, 2'b00, 7'h31, 2'd0, 3'd0, 7'd0,  3'd0, 0};
        vecs[3]  = '{8'h0C, 3'b000, 2'b10, 7'h31, 2'd0, 3'd0, 7'd0,  3'd0, 0};
        vecs[4]  = '{8'hC5, 3'b000, 2'b10, 7'h31, 2'd0, 3'd0, 7'd69, 3'd0, 0};
        vecs[5]  = '{8'hD4, 3'b000, 2'b10, 7'h31, 2'd0, 3'd0, 7'd69, 3'd0, 1};
        vecs[6]  = '{8'h43, 3'b000, 2'b10, 7'h31, 2'd0, 3'd0, 7'd69, 3'd3, 0};
        vecs[7]  = '{8'h46, 3'b000, 2'b10, 7'h31, 2'd0, 3'd0, 7'd69, 3'd3, 1};
        vecs[8]  = '{8'h00, 3'b000, 2'b10, 7'h31, 2'd0, 3'd0, 7'd69, 3'd3, 0};
        vecs[9]  = '{8'h10, 3'b000, 2'b10, 7'h31, 2'd0, 3'd0, 7'd69, 3'd3, 1};
        vecs[10] = '{8'h21, 3'b001, 2'b10, 7'h31, 2'd0, 3'd0, 7'd69, 3'd3, 0};
        vecs[11] = '{8'h06, 3'b001, 2'b10, 7'h31, 2'd2, 3'd0, 7'd69, 3'd3, 0};
        vecs[12] = '{8'h13, 3'b001, 2'b10, 7'h31, 2'd2, 3'd3, 7'd69, 3'd3, 0};
        vecs[13] = '{8'h0C, 3'b001, 2'b10, 7'h31, 2'd2, 3'd3, 7'd69, 3'd3, 1};
        vecs[14] = '{8'h20, 3'b000, 2'b10, 7'h31, 2'd2, 3'd3, 7'd69, 3'd3, 0};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_regs", {pd_v_h, disp_de, vop, tc, bias, x_o, y_o},
              {3'b100, 2'b00, 7'd0, 2'd0, 3'd0, 7'd0, 3'd0});
        check("reset_pulses", {byte_dv, cmd_err, frame_done, byte_o}, 0);

        // Command decode table
        for (int i = 0; i < 15; i++) begin
            e0 = err_cnt;
            send_byte(vecs[i].b, 1'b0);
            check($sformatf("cmd%0d_regs", i), {pd_v_h, disp_de, vop, tc, bias, x_o, y_o},
                  {vecs[i].pvh, vecs[i].de, vecs[i].vop, vecs[i].tc, vecs[i].bias,
                   vecs[i].x, vecs[i].y});
            check($sformatf("cmd%0d_err", i), 64'(err_cnt - e0), 64'(vecs[i].err));
        end

        // Full frame in horizontal mode
        send_byte(8'h80, 1'b0);
        send_byte(8'h40, 1'b0);
        f0 = fd_cnt;
        for (int i = 0; i < 503; i++) send_byte(8'(i), 1'b1);
        check("frame_no_early_done", 64'(fd_cnt - f0), 0);
        send_byte(8'(503), 1'b1);
        check("frame_done_once", 64'(fd_cnt - f0), 1);
        check("frame_xy_wrap", {x_o, y_o}, 0);
        for (int i = 0; i < 504; i++) begin
            read_fb(i, d);
            check($sformatf("fb[%0d]", i), d, 64'(i % 256));
        end

        // Last-cell write then wrap
        f0 = fd_cnt;
        send_byte(8'hD3, 1'b0);
        send_byte(8'h45, 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        read_fb(503, d);
        check("last_cell", d, 8'hAA);
        read_fb(0, d);
        check("first_after_wrap", d, 8'h55);
        check("last_frame_done", 64'(fd_cnt - f0), 1);

        // Vertical addressing
        send_byte(8'h22, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h40, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(8'h11 + 8'(i), 1'b1);
        begin
            int addrs[7] = '{0, 84, 168, 252, 336, 420, 1};
            for (int i = 0; i < 7; i++) begin
                read_fb(addrs[i], d);
                check($sformatf("vert_%0d", addrs[i]), d, 64'(8'h11 + 8'(i)));
            end
        end
        check("vert_xy", {x_o, y_o}, {7'd1, 3'd1});

        // Aborted partial byte, then a clean data byte
        send_byte(8'h20, 1'b0);
        send_byte(8'h8A, 1'b0);
        send_byte(8'h42, 1'b0);
        v0 = dv_cnt;
        ce = 1'b0;
        dc = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        repeat (2) @(negedge clk);
        ce = 1'b1;
        repeat (6) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        check("abort_one_dv", 64'(dv_cnt - v0), 1);
        check("abort_byte", {byte_o, byte_is_data}, {8'hA5, 1'b1});
        read_fb(178, d);
        check("abort_write", d, 8'hA5);
        check("abort_x", x_o, 7'd11);

        // Bad Y, then LCD reset mid-byte
        e0 = err_cnt;
        send_byte(8'h47, 1'b0);
        check("bad_y_err", 64'(err_cnt - e0), 1);
        check("bad_y_kept", y_o, 3'd2);
        ce = 1'b0;
        dc = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        lcd_rst = 1'b0;
        repeat (5) @(negedge clk);
        lcd_rst = 1'b1;
        ce = 1'b1;
        repeat (5) @(negedge clk);
        check("lcd_rst_regs", {pd_v_h, disp_de, vop, tc, bias, x_o, y_o},
              {3'b100, 2'b00, 7'd0, 2'd0, 3'd0, 7'd0, 3'd0});
        read_fb(178, d);
        check("lcd_rst_fb_kept", d, 8'hA5);
        v0 = dv_cnt;
        send_byte(8'h77, 1'b1);
        read_fb(0, d);
        check("pd_write_ignored", d, 8'h11);
        check("pd_ptr_held", {x_o, y_o}, 0);
        send_byte(8'h20, 1'b0);
        check("post_rst_cmd", {pd_v_h, byte_o}, {3'b000, 8'h20});
        check("post_rst_dv", 64'(dv_cnt - v0), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
